// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d, borrow_q, borrow_d;
  logic             d_bit, bw_nx;
`ifdef SERIAL_SUB_OVF_EN
  logic             asgn_q, asgn_d, bsgn_q, bsgn_d, ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  assign d_bit = a_q[0] ^ b_q[0] ^ bw_q;
  assign bw_nx = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    asgn_d   = asgn_q;
    bsgn_d   = bsgn_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          bw_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          asgn_d  = a[WIDTH-1];
          bsgn_d  = b[WIDTH-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = {d_bit, res_q[WIDTH-1:1]};
        bw_d  = bw_nx;
        cnt_d = cnt_q + 1'b1;
        // Outputs are loaded on the last shift edge so they are valid throughout DONE
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = res_d;
          borrow_d = bw_nx;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (asgn_q != bsgn_q) && (d_bit != asgn_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bw_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      asgn_q   <= 1'b0;
      bsgn_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      asgn_q   <= asgn_d;
      bsgn_q   <= bsgn_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with an operation-level reference model.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an accepted op finishes W edges later with plain arithmetic results.
  int           rem;
  logic [W-1:0] opa, opb, m_diff;
  logic         m_done, m_borrow, m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; m_done <= 1'b0; m_diff <= '0; m_borrow <= 1'b0; m_ovf <= 1'b0;
      opa <= '0; opb <= '0;
    end else begin
      m_done <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done   <= 1'b1;
          m_diff   <= opa - opb;
          m_borrow <= (opa < opb);
          m_ovf    <= (opa[W-1] != opb[W-1]) && (((opa - opb) >> (W-1)) != W'(opa[W-1]));
        end
      end else if (start) begin
        opa <= a; opb <= b; rem <= W;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (busy !== (rem != 0) || done !== m_done || diff !== m_diff || borrow_out !== m_borrow) begin
      miscompares++;
      $display("FAIL model t=%0t busy=%b done=%b diff=%h bo=%b required busy=%b done=%b diff=%h bo=%b",
               $time, busy, done, diff, borrow_out, rem != 0, m_done, m_diff, m_borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    vectors++;
    if (ovf !== m_ovf) begin
      miscompares++;
      $display("FAIL model_ovf t=%0t ovf=%b required %b", $time, ovf, m_ovf);
    end
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns edges until done is seen (0 on timeout).
  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin k = i; break; end
    end
    if (k == 0) begin
      vectors++; miscompares++;
      $display("FAIL timeout waiting for done actual=none required=done");
    end
  endtask

  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] ediff, input logic eb);
    int k;
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(k);
    chk({name, "_lat"}, k, W);
    chk({name, "_diff"}, diff, ediff);
    chk({name, "_borrow"}, borrow_out, eb);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_diff", diff, 0); chk("rst_borrow", borrow_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("5m3", 8'h05, 8'h03, 8'h02, 1'b0);
    do_op("3m5", 8'h03, 8'h05, 8'hFE, 1'b1);
    do_op("0mFF", 8'h00, 8'hFF, 8'h01, 1'b1);
    repeat (3) @(posedge clk); #1;

    // A == B, then back-to-back start in the DONE cycle
    do_op("eq", 8'hA5, 8'hA5, 8'h00, 1'b0);
    do_op("b2b", 8'h10, 8'h01, 8'h0F, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Start pulse while busy is ignored; operand changes after capture have no effect
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(k);
    chk("ign_lat", k, W - 4);
    chk("ign_diff", diff, 8'h02);
    chk("ign_borrow", borrow_out, 0);
    repeat (3) @(posedge clk); #1;

    // Reset during bit 4 of 0x80 - 0x01
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0); chk("mid_rst_borrow", borrow_out, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        vectors++; miscompares++;
        $display("FAIL no_done_after_rst actual=done required=none");
      end
    end
    do_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf_80m01", ovf, 1);
    do_op("7FmFF", 8'h7F, 8'hFF, 8'h80, 1'b1);
    chk("ovf_7FmFF", ovf, 1);
    do_op("10m01o", 8'h10, 8'h01, 8'h0F, 1'b0);
    chk("ovf_10m01", ovf, 0);
`endif
    repeat (2) @(posedge clk); #1;

    // start held high with operands changing every cycle; model checks each op
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("final_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
